// File: rtl/dispatch_queue.sv
// Instruction queue + head decode/operand resolution + single-issue dispatch.
// Define DISPATCH_PERF_EN to add saturating dispatch/stall performance counters.
module dispatch_queue #(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 8,
  parameter int IQ_DEPTH = 4,
  parameter int NUM_FU   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              flush,
  input  logic [NUM_FU-1:0] fu_busy,
  input  logic              rob_ready,
  input  logic [TAG_W-1:0]  rob_tag,
  output logic [4:0]        reg_rs1,
  output logic [4:0]        reg_rs2,
  input  logic [XLEN-1:0]   reg1_data,
  input  logic [XLEN-1:0]   reg2_data,
  input  logic [TAG_W-1:0]  reg1_tag,
  input  logic [TAG_W-1:0]  reg2_tag,
  output logic [TAG_W-1:0]  rob_tag1,
  output logic [TAG_W-1:0]  rob_tag2,
  input  logic              rob_hit1,
  input  logic              rob_hit2,
  input  logic [XLEN-1:0]   rob_val1,
  input  logic [XLEN-1:0]   rob_val2,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [XLEN-1:0]   cdb_val,
  output logic              out_valid,
  output logic [1:0]        out_fu,
  output logic [6:0]        out_opcode,
  output logic [2:0]        out_fun3,
  output logic [6:0]        out_fun7,
  output logic [TAG_W-1:0]  out_q1,
  output logic [TAG_W-1:0]  out_q2,
  output logic [XLEN-1:0]   out_v1,
  output logic [XLEN-1:0]   out_v2,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_pc,
  output logic [4:0]        out_rd,
  output logic [TAG_W-1:0]  out_rob_tag,
  output logic              rob_write,
  output logic              reg_write,
  output logic              illegal
`ifdef DISPATCH_PERF_EN
  ,
  output logic [31:0]       perf_dispatch,
  output logic [31:0]       perf_stall_fu,
  output logic [31:0]       perf_stall_rob
`endif
);
  localparam int AW = $clog2(IQ_DEPTH);
  localparam int PW = AW + 1;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_L = 7'b0000011,
                         OP_S = 7'b0100011, OP_B = 7'b1100011, OP_JALR = 7'b1100111,
                         OP_JAL = 7'b1101111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [1:0] FU_ALU = 2'd0, FU_MUL = 2'd1, FU_LS = 2'd2, FU_BR = 2'd3;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
  } iq_ent_t;

  typedef struct packed {
    logic [TAG_W-1:0] q;
    logic [XLEN-1:0]  v;
  } opnd_t;

  iq_ent_t       iq [IQ_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, empty, push, fire, drop;
  iq_ent_t       head;
  logic [31:0]   inst;
  opnd_t         src1, src2;
  logic          legal, wr_rd;
  logic [1:0]    cls;
  logic [TAG_W-1:0] d_q1, d_q2;
  logic [XLEN-1:0]  d_v1, d_v2, d_imm;
  logic [XLEN-1:0]  imm_i, imm_s, imm_b, imm_u, imm_j;

  // Priority: regfile value, then ROB forward, then same-cycle CDB snoop.
  function automatic opnd_t resolve(input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] rf,
                                    input logic hit, input logic [XLEN-1:0] rv,
                                    input logic cv, input logic [TAG_W-1:0] ct,
                                    input logic [XLEN-1:0] cval);
    resolve = '0;
    if (tag == '0)               resolve.v = rf;
    else if (hit)                resolve.v = rv;
    else if (cv && (ct == tag))  resolve.v = cval;
    else                         resolve.q = tag;
  endfunction

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = iq[rd_ptr[AW-1:0]];
  assign inst  = head.inst;

  assign in_ready  = !full;
  assign reg_rs1   = inst[19:15];
  assign reg_rs2   = inst[24:20];
  assign rob_tag1  = reg1_tag;
  assign rob_tag2  = reg2_tag;
  assign rob_write = out_valid;

  assign src1 = resolve(reg1_tag, reg1_data, rob_hit1, rob_val1, cdb_valid, cdb_tag, cdb_val);
  assign src2 = resolve(reg2_tag, reg2_data, rob_hit2, rob_val2, cdb_valid, cdb_tag, cdb_val);

  assign imm_i = XLEN'($signed(inst[31:20]));
  assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
  assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

  always_comb begin
    legal = 1'b1;
    wr_rd = 1'b1;
    cls   = FU_ALU;
    d_q1  = '0;
    d_q2  = '0;
    d_v1  = '0;
    d_v2  = '0;
    d_imm = '0;
    case (inst[6:0])
      OP_R:     begin d_q1 = src1.q; d_v1 = src1.v; d_q2 = src2.q; d_v2 = src2.v;
                      cls = (inst[31:25] == 7'b0000001) ? FU_MUL : FU_ALU; end
      OP_I:     begin d_q1 = src1.q; d_v1 = src1.v; d_imm = imm_i; end
      OP_L:     begin d_q1 = src1.q; d_v1 = src1.v; d_imm = imm_i; cls = FU_LS; end
      OP_S:     begin d_q1 = src1.q; d_v1 = src1.v; d_q2 = src2.q; d_v2 = src2.v;
                      d_imm = imm_s; cls = FU_LS; wr_rd = 1'b0; end
      OP_B:     begin d_q1 = src1.q; d_v1 = src1.v; d_q2 = src2.q; d_v2 = src2.v;
                      d_imm = imm_b; cls = FU_BR; wr_rd = 1'b0; end
      OP_JALR:  begin d_q1 = src1.q; d_v1 = src1.v; d_v2 = head.pc; d_imm = imm_i; cls = FU_BR; end
      OP_JAL:   begin d_v2 = head.pc; d_imm = imm_j; cls = FU_BR; end
      OP_LUI:   d_imm = imm_u;
      OP_AUIPC: begin d_v1 = head.pc; d_imm = imm_u; end
      default:  legal = 1'b0;
    endcase
  end

  // Flush gates both push and issue so nothing from the wrong path survives.
  assign push = in_valid && !full && !flush;
  assign fire = !empty && !flush && legal && rob_ready && !fu_busy[cls];
  assign drop = !empty && !flush && !legal;

  always_ff @(posedge clk) begin
    if (push) iq[wr_ptr[AW-1:0]] <= '{inst: in_inst, pc: in_pc};
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)         wr_ptr <= wr_ptr + PW'(1);
      if (fire || drop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      illegal     <= 1'b0;
      reg_write   <= 1'b0;
      out_fu      <= '0;
      out_opcode  <= '0;
      out_fun3    <= '0;
      out_fun7    <= '0;
      out_q1      <= '0;
      out_q2      <= '0;
      out_v1      <= '0;
      out_v2      <= '0;
      out_imm     <= '0;
      out_pc      <= '0;
      out_rd      <= '0;
      out_rob_tag <= '0;
    end else begin
      out_valid <= fire;
      illegal   <= drop;
      reg_write <= fire && wr_rd && (inst[11:7] != 5'd0);
      if (fire) begin
        out_fu      <= cls;
        out_opcode  <= inst[6:0];
        out_fun3    <= inst[14:12];
        out_fun7    <= inst[31:25];
        out_q1      <= d_q1;
        out_q2      <= d_q2;
        out_v1      <= d_v1;
        out_v2      <= d_v2;
        out_imm     <= d_imm;
        out_pc      <= head.pc;
        out_rd      <= inst[11:7];
        out_rob_tag <= rob_tag;
      end
    end
  end

`ifdef DISPATCH_PERF_EN
  logic stall_fu, stall_rob;
  // A busy class outranks a full ROB when both block the head.
  assign stall_fu  = !empty && !flush && legal && fu_busy[cls];
  assign stall_rob = !empty && !flush && legal && !fu_busy[cls] && !rob_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_dispatch  <= '0;
      perf_stall_fu  <= '0;
      perf_stall_rob <= '0;
    end else begin
      if (fire && (perf_dispatch != '1))       perf_dispatch  <= perf_dispatch + 32'd1;
      if (stall_fu && (perf_stall_fu != '1))   perf_stall_fu  <= perf_stall_fu + 32'd1;
      if (stall_rob && (perf_stall_rob != '1)) perf_stall_rob <= perf_stall_rob + 32'd1;
    end
  end
`endif

endmodule
